baseball_scoreboard: RTL and testbench

- Downstream consumer of the base-runner tracker's occupancy bus and hit strobes.
- Computes the runs scored on each hit from the pre-hit occupancy, and accumulates home and away scores.
- Counts outs, sequences half-innings and innings, and decides game end (walk-off and extra innings).
- On each half-inning change it drives a clear request that the top level feeds back to the base tracker.

---
 rtl/baseball_scoreboard_if.sv | 18 +
 rtl/baseball_scoreboard.sv | 93 +++++++++
 tb/tb_baseball_scoreboard.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/baseball_scoreboard_if.sv
// baseball_scoreboard_if: hit/occupancy/out inputs and score/inning outputs of the scoreboard.
interface baseball_scoreboard_if #(parameter int SCORE_W = 8);
    logic [3:0]         hit;
    logic [2:0]         base_in;
    logic               out_strobe;
    logic [SCORE_W-1:0] score_away;
    logic [SCORE_W-1:0] score_home;
    logic [1:0]         outs;
    logic [4:0]         inning;
    logic               bottom;
    logic [2:0]         runs_play;
    logic               base_clr;
    logic               game_over;
    modport master (output hit, base_in, out_strobe,
                    input  score_away, score_home, outs, inning, bottom, runs_play, base_clr, game_over);
    modport slave  (input  hit, base_in, out_strobe,
                    output score_away, score_home, outs, inning, bottom, runs_play, base_clr, game_over);
endinterface

// File: rtl/baseball_scoreboard.sv
// baseball_scoreboard: scores hits from pre-hit occupancy, counts outs/innings and decides game end.
// Optional mercy rule enabled by defining MERCY_RULE_EN.
module baseball_scoreboard #(
    parameter int SCORE_W       = 8,
    parameter int INNINGS       = 9,
    parameter int OUTS_PER_HALF = 3,
    parameter int MERCY_LEAD    = 10,
    parameter int MERCY_INNING  = 7
) (
    input logic clk,
    input logic reset_n,
    baseball_scoreboard_if.slave bus
);
`ifdef MERCY_RULE_EN
    localparam bit MERCY_ON = 1'b1;
`else
    localparam bit MERCY_ON = 1'b0;
`endif
    typedef enum logic [1:0] {PLAY, CLR, OVER} state_e;
    state_e             state_q, state_d;
    logic [SCORE_W-1:0] away_q, away_d, home_q, home_d, sat, lead;
    logic [SCORE_W:0]   sum;
    logic [1:0]         outs_q, outs_d, outs_inc;
    logic [4:0]         inning_q, inning_d;
    logic               bottom_q, bottom_d;
    logic [2:0]         runs_q, runs_d, runs;
    logic               f, s, t, valid_hit, half_end, late, mercy;
    assign {f, s, t} = bus.base_in;
    always_comb begin
        valid_hit = $onehot(bus.hit);
        // hit[3] is a single, hit[0] a home run
        runs      = {2'b0, t} + (bus.hit[3] ? 3'd0 : {2'b0, s})
                  + ((bus.hit[1] | bus.hit[0]) ? {2'b0, f} : 3'd0) + {2'b0, bus.hit[0]};
        sum       = {1'b0, bottom_q ? home_q : away_q} + (SCORE_W+1)'(runs);
        sat       = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        outs_inc  = outs_q + 2'd1;
        half_end  = 32'(outs_inc) == OUTS_PER_HALF;
        late      = 32'(inning_q) >= INNINGS;
        lead      = home_q >= away_q ? home_q - away_q : away_q - home_q;
        mercy     = MERCY_ON && 32'(inning_q) >= MERCY_INNING && 32'(lead) >= MERCY_LEAD;
        state_d   = state_q;
        away_d    = away_q;
        home_d    = home_q;
        outs_d    = outs_q;
        inning_d  = inning_q;
        bottom_d  = bottom_q;
        runs_d    = runs_q;
        if (state_q == CLR) begin
            state_d = PLAY;
        end else if (state_q == PLAY && valid_hit) begin
            runs_d = runs;
            home_d = bottom_q ? sat : home_q;
            away_d = bottom_q ? away_q : sat;
            state_d = (bottom_q && late && sat > away_q) ? OVER : PLAY;
        end else if (state_q == PLAY && bus.out_strobe) begin
            outs_d = half_end ? 2'd0 : outs_inc;
            if (half_end && (mercy || (late && (bottom_q ? home_q != away_q : home_q > away_q)))) begin
                state_d = OVER;
            end else if (half_end) begin
                state_d  = CLR;
                bottom_d = !bottom_q;
                inning_d = (bottom_q && inning_q != 5'd31) ? inning_q + 5'd1 : inning_q;
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= PLAY;
            away_q   <= '0;
            home_q   <= '0;
            outs_q   <= '0;
            inning_q <= 5'd1;
            bottom_q <= 1'b0;
            runs_q   <= '0;
        end else begin
            state_q  <= state_d;
            away_q   <= away_d;
            home_q   <= home_d;
            outs_q   <= outs_d;
            inning_q <= inning_d;
            bottom_q <= bottom_d;
            runs_q   <= runs_d;
        end
    end
    assign bus.score_away = away_q;
    assign bus.score_home = home_q;
    assign bus.outs       = outs_q;
    assign bus.inning     = inning_q;
    assign bus.bottom     = bottom_q;
    assign bus.runs_play  = runs_q;
    assign bus.base_clr   = state_q == CLR;
    assign bus.game_over  = state_q == OVER;
endmodule

// File: tb/tb_baseball_scoreboard.sv
// tb_baseball_scoreboard: directed and random play checked against a runner-advance scoring model.
module tb_baseball_scoreboard;
    localparam int SW   = 8;
    localparam int INN  = 9;
    localparam int OPH  = 3;
    localparam int MAXS = (1 << SW) - 1;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    baseball_scoreboard_if #(.SCORE_W(SW)) bus ();
    baseball_scoreboard #(.SCORE_W(SW), .INNINGS(INN), .OUTS_PER_HALF(OPH)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    int n_chk = 0;
    int n_err = 0;
    int m_away, m_home, m_outs, m_inn, m_bot, m_runs, m_clr, m_over;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/away"},  32'(bus.score_away), m_away);
        check({tag, "/home"},  32'(bus.score_home), m_home);
        check({tag, "/outs"},  32'(bus.outs),       m_outs);
        check({tag, "/inn"},   32'(bus.inning),     m_inn);
        check({tag, "/bot"},   32'(bus.bottom),     m_bot);
        check({tag, "/runs"},  32'(bus.runs_play),  m_runs);
        check({tag, "/clr"},   32'(bus.base_clr),   m_clr);
        check({tag, "/over"},  32'(bus.game_over),  m_over);
    endtask

    task automatic m_reset();
        m_away = 0; m_home = 0; m_outs = 0; m_inn = 1;
        m_bot = 0; m_runs = 0; m_clr = 0; m_over = 0;
    endtask

    // runners advance n bases on an n-base hit; anyone reaching home scores
    task automatic m_step(input logic [3:0] h, input logic [2:0] b, input logic o);
        int n, r;
        if (m_over != 0) begin
        end else if (m_clr != 0) begin
            m_clr = 0;
        end else if ($countones(h) == 1) begin
            n = h[3] ? 1 : h[2] ? 2 : h[1] ? 3 : 4;
            r = (b[2] && 1 + n >= 4 ? 1 : 0) + (b[1] && 2 + n >= 4 ? 1 : 0)
              + (b[0] ? 1 : 0) + (n == 4 ? 1 : 0);
            m_runs = r;
            if (m_bot != 0) m_home = (m_home + r > MAXS) ? MAXS : m_home + r;
            else            m_away = (m_away + r > MAXS) ? MAXS : m_away + r;
            if (m_bot != 0 && m_inn >= INN && m_home > m_away) m_over = 1;
        end else if (o) begin
            m_outs++;
            if (m_outs == OPH) begin
                m_outs = 0;
                if (m_inn >= INN && (m_bot != 0 ? m_home != m_away : m_home > m_away)) m_over = 1;
                else begin
                    m_clr = 1;
                    if (m_bot != 0 && m_inn < 31) m_inn++;
                    m_bot = (m_bot != 0) ? 0 : 1;
                end
            end
        end
    endtask

    task automatic step(input logic [3:0] h, input logic [2:0] b, input logic o, input string tag);
        bus.hit = h;
        bus.base_in = b;
        bus.out_strobe = o;
        m_step(h, b, o);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        m_reset();
        #1;
        check_all(tag);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic end_half(input string tag);
        for (int i = 0; i < OPH; i++) step(4'b0000, 3'b000, 1'b1, tag);
        step(4'b0001, 3'b111, 1'b0, {tag, "_drop"});
    endtask

    initial begin
        bus.hit = '0;
        bus.base_in = '0;
        bus.out_strobe = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;
        step(4'b0001, 3'b111, 1'b0, "grand_slam");
        step(4'b1000, 3'b101, 1'b0, "single_101");
        step(4'b1000, 3'b010, 1'b0, "single_010");
        step(4'b1100, 3'b111, 1'b0, "invalid_hit");
        step(4'b0000, 3'b111, 1'b0, "no_hit");
        step(4'b0100, 3'b011, 1'b1, "hit_and_out");
        end_half("three_outs");
        for (int i = 0; i < 400; i++) begin
            logic [3:0] h;
            int sel = $urandom_range(0, 9);
            h = sel < 5 ? 4'b0000 : sel < 8 ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
            step(h, 3'($urandom), 1'($urandom_range(0, 9) < 4), "random");
        end
        do_reset("rst_a");
        for (int i = 0; i < 3; i++) step(4'b1000, 3'b001, 1'b0, "a_top1");
        end_half("a_end");
        for (int i = 0; i < 3; i++) step(4'b1000, 3'b001, 1'b0, "a_bot1");
        for (int i = 0; i < 16; i++) end_half("a_adv");
        step(4'b1000, 3'b001, 1'b0, "walkoff");
        step(4'b0001, 3'b111, 1'b0, "over_hit");
        step(4'b0000, 3'b000, 1'b1, "over_out");
        do_reset("rst_b");
        step(4'b0100, 3'b010, 1'b0, "b_top1");
        step(4'b1000, 3'b001, 1'b0, "b_top1");
        end_half("b_end");
        step(4'b0001, 3'b111, 1'b0, "b_bot1");
        step(4'b0010, 3'b000, 1'b0, "b_bot1");
        for (int i = 0; i < 15; i++) end_half("b_adv");
        end_half("skip_bottom");
        do_reset("rst_c");
        step(4'b0010, 3'b101, 1'b0, "c_top1");
        end_half("c_end");
        step(4'b0100, 3'b011, 1'b0, "c_bot1");
        for (int i = 0; i < 16; i++) end_half("c_adv");
        end_half("extra_inning");
        step(4'b0001, 3'b000, 1'b0, "c_top10");
        do_reset("rst_d");
        for (int i = 0; i < 70; i++) step(4'b0001, 3'b111, 1'b0, "saturate");
        step(4'b0000, 3'b000, 1'b1, "e_out1");
        step(4'b0000, 3'b000, 1'b1, "e_out2");
        step(4'b0000, 3'b000, 1'b1, "e_out3");
        do_reset("async_rst");
        step(4'b1000, 3'b001, 1'b0, "after_rst");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
